// File: rtl/div_restoring.sv
// div_restoring: iterative radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics
module div_restoring #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  output logic         in_ready,
  input  logic         in_valid,
  input  logic         in_sign,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_quot,
  output logic [W-1:0] out_rem
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic sa, sb, neg_a, neg_b, accept, div_zero, ovf, last;
  logic [W-1:0] ab, q, r, abs_a, abs_b;
  logic [W:0] t;
  assign in_ready  = (state == IDLE) | flush | ((state == HOLD) & out_ready);
  assign out_valid = (state == HOLD) & ~flush;
  assign accept    = in_valid & in_ready;
  assign neg_a     = in_sign & in_a[W-1];
  assign neg_b     = in_sign & in_b[W-1];
  assign abs_a     = neg_a ? -in_a : in_a;
  assign abs_b     = neg_b ? -in_b : in_b;
  assign div_zero  = in_b == '0;
  assign ovf       = in_sign & (in_a == {1'b1, {(W-1){1'b0}}}) & (in_b == '1);
  assign last      = cnt == CW'(W - 1);
  // trial subtraction of the divisor from the partial remainder shifted left by one quotient bit
  assign t         = {r, q[W-1]} - {1'b0, ab};
  assign out_quot  = q;
  assign out_rem   = r;
  // state register; reset lands in IDLE so nothing stale is presented afterwards
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: a new operand pair wins over flush, flush over normal progress
  always_comb begin
    state_nx = state;
    if (accept) state_nx = (div_zero | ovf) ? HOLD : CALC;
    else if (flush) state_nx = IDLE;
    else if (state == CALC) state_nx = last ? FIX : CALC;
    else if (state == FIX) state_nx = HOLD;
    else if (state == HOLD) state_nx = out_ready ? IDLE : HOLD;
  end
  // iteration counter, restarted on every accept
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (accept) cnt <= '0;
    else if (state == CALC) cnt <= cnt + 1'b1;
  // datapath: q doubles as dividend shifter and quotient, r is the partial remainder
  always_ff @(posedge clock)
    if (accept) begin
      sa <= neg_a;
      sb <= neg_b;
      ab <= abs_b;
      q  <= div_zero ? '1 : ovf ? in_a : abs_a;
      r  <= div_zero ? in_a : '0;
    end else if (state == CALC) begin
      r <= t[W] ? {r[W-2:0], q[W-1]} : t[W-1:0];
      q <= {q[W-2:0], ~t[W]};
    end else if (state == FIX) begin
      q <= (sa ^ sb) ? -q : q;
      r <= sa ? -r : r;
    end
endmodule
